// File: rtl/dispensador_troco_pkg.sv
// Shared types and helpers for the vending-machine change path.
// Holds the change-dispenser state enum and the saturating subtraction used for change amounts.
package pkg_maquina;

  typedef enum logic [2:0] {
    IDLE,
    CARGA,
    PULSO,
    ESPERA,
    PAUSA,
    FIM,
    ERRO
  } t_estado_troco;

  localparam int LARG_VALOR_PADRAO = 4;

  function automatic logic [15:0] sub_sat(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'd0;
  endfunction

endpackage

// File: rtl/dispensador_troco_if.sv
// Request, sensor and status bundle between vending control and the change dispenser.
// master = control side driving requests/sensor, slave = dispenser.
interface dispensador_troco_if #(
  parameter int LARG_VALOR = 4
);
  logic                  liberar;
  logic                  devolver;
  logic [LARG_VALOR-1:0] valor_moedas;
  logic [2:0]            valor_produto;
  logic                  sensor_moeda;
  logic                  limpar_erro;
  logic                  ejetar;
  logic                  ocupado;
  logic                  concluido;
  logic                  erro;
  logic [LARG_VALOR-1:0] troco_pendente;

  modport master (
    output liberar, devolver, valor_moedas, valor_produto, sensor_moeda, limpar_erro,
    input  ejetar, ocupado, concluido, erro, troco_pendente
  );

  modport slave (
    input  liberar, devolver, valor_moedas, valor_produto, sensor_moeda, limpar_erro,
    output ejetar, ocupado, concluido, erro, troco_pendente
  );
endinterface

// File: rtl/dispensador_troco_borda.sv
// Rising-edge pulse generator with an optional 2-flop synchronizer in front.
// Edge pulse is combinational from the (synchronized) sample: 0 cycles direct, 2 cycles synchronized.
module detector_borda #(
  parameter bit SINCRONIZAR = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sinal,
  output logic borda
);

  logic amostra;
  logic anterior;

  generate
    if (SINCRONIZAR) begin : gSinc
      logic estagio1;
      logic estagio2;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          estagio1 <= 1'b0;
          estagio2 <= 1'b0;
        end else begin
          estagio1 <= sinal;
          estagio2 <= estagio1;
        end
      end
      assign amostra = estagio2;
    end else begin : gDireto
      assign amostra = sinal;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) anterior <= 1'b0;
    else          anterior <= amostra;
  end

  assign borda = amostra & ~anterior;

endmodule

// File: rtl/dispensador_troco.sv
// Change/refund dispenser: one solenoid pulse per coin, retry on missing drop, sticky fault after MAX_TENTATIVAS.
// Optional SENSOR_SINCRONIZADOR_EN puts a 2-flop synchronizer on sensor_moeda (sensor-to-decrement 3 cycles instead of 1).
module dispensador_troco
  import pkg_maquina::*;
#(
  parameter int PULSO_CICLOS   = 4,
  parameter int ESPERA_CICLOS  = 16,
  parameter int PAUSA_CICLOS   = 2,
  parameter int MAX_TENTATIVAS = 3,
  parameter int LARG_VALOR     = LARG_VALOR_PADRAO
) (
  input logic                 clk,
  input logic                 reset_n,
  dispensador_troco_if.slave  bus
);

`ifdef SENSOR_SINCRONIZADOR_EN
  localparam bit SINC_SENSOR = 1'b1;
`else
  localparam bit SINC_SENSOR = 1'b0;
`endif

  localparam int MAIOR_PE  = (PULSO_CICLOS > ESPERA_CICLOS) ? PULSO_CICLOS : ESPERA_CICLOS;
  localparam int MAIOR     = (MAIOR_PE > PAUSA_CICLOS) ? MAIOR_PE : PAUSA_CICLOS;
  localparam int LARG_CONT = $clog2(MAIOR + 1);
  localparam int LARG_TENT = $clog2(MAX_TENTATIVAS + 1);

  t_estado_troco         estado;
  t_estado_troco         proxEstado;
  logic [LARG_CONT-1:0]  temporizador;
  logic [LARG_TENT-1:0]  tentativas;
  logic [LARG_VALOR-1:0] montante;
  logic [LARG_VALOR-1:0] montanteNovo;
  logic                  pedido;
  logic                  bordaPedido;
  logic                  bordaSensor;
  logic                  fimPulso;
  logic                  fimEspera;
  logic                  fimPausa;
  logic                  esgotou;

  assign pedido = bus.liberar | bus.devolver;

  detector_borda #(.SINCRONIZAR(1'b0)) uBordaPedido (
    .clk     (clk),
    .reset_n (reset_n),
    .sinal   (pedido),
    .borda   (bordaPedido)
  );

  detector_borda #(.SINCRONIZAR(SINC_SENSOR)) uBordaSensor (
    .clk     (clk),
    .reset_n (reset_n),
    .sinal   (bus.sensor_moeda),
    .borda   (bordaSensor)
  );

  // Refund wins over change when both requests rise together.
  assign montanteNovo = bus.devolver ? bus.valor_moedas
                      : LARG_VALOR'(sub_sat(16'(bus.valor_moedas), 16'(bus.valor_produto)));

  assign fimPulso  = (temporizador == LARG_CONT'(PULSO_CICLOS - 1));
  assign fimEspera = (temporizador == LARG_CONT'(ESPERA_CICLOS - 1));
  assign fimPausa  = (temporizador == LARG_CONT'(PAUSA_CICLOS - 1));
  assign esgotou   = (tentativas == LARG_TENT'(MAX_TENTATIVAS - 1));

  always_comb begin
    proxEstado = estado;
    case (estado)
      IDLE:    if (bordaPedido) proxEstado = CARGA;
      CARGA:   proxEstado = (montante == '0) ? FIM : PULSO;
      PULSO: begin
        if (bordaSensor)   proxEstado = PAUSA;
        else if (fimPulso) proxEstado = ESPERA;
      end
      ESPERA: begin
        if (bordaSensor)    proxEstado = PAUSA;
        else if (fimEspera) proxEstado = esgotou ? ERRO : PAUSA;
      end
      PAUSA:   if (fimPausa) proxEstado = (bus.troco_pendente != '0) ? PULSO : FIM;
      FIM:     proxEstado = IDLE;
      ERRO:    if (bus.limpar_erro) proxEstado = IDLE;
      default: proxEstado = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado             <= IDLE;
      temporizador       <= '0;
      tentativas         <= '0;
      montante           <= '0;
      bus.troco_pendente <= '0;
      bus.ejetar         <= 1'b0;
      bus.ocupado        <= 1'b0;
      bus.concluido      <= 1'b0;
      bus.erro           <= 1'b0;
    end else begin
      estado <= proxEstado;

      if (proxEstado != estado || !(estado inside {PULSO, ESPERA, PAUSA}))
        temporizador <= '0;
      else
        temporizador <= temporizador + LARG_CONT'(1);

      if (estado == IDLE && bordaPedido)
        montante <= montanteNovo;

      case (estado)
        CARGA: begin
          bus.troco_pendente <= montante;
          tentativas         <= '0;
        end
        PULSO, ESPERA: begin
          if (bordaSensor) begin
            bus.troco_pendente <= bus.troco_pendente - LARG_VALOR'(1);
            tentativas         <= '0;
          end else if (estado == ESPERA && fimEspera) begin
            tentativas <= tentativas + LARG_TENT'(1);
          end
        end
        default: ;
      endcase

      bus.ejetar    <= (proxEstado == PULSO);
      bus.ocupado   <= (proxEstado inside {CARGA, PULSO, ESPERA, PAUSA, FIM});
      bus.concluido <= (proxEstado == FIM);
      bus.erro      <= (proxEstado == ERRO);
    end
  end

endmodule
